// File: rtl/aes_gf_pkg.sv
// Shared GF(((2^2)^2)^2) arithmetic, basis maps and FSM encoding for the AES S-box datapaths.
// Tower: GF(4) w^2=w+1; GF(16) Y^2=Y+w; GF(256) Z^2=Z+wY; composite bit j is the coefficient of basis product j.
package aes_gf_pkg;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_e;
   typedef logic [7:0][7:0] bmat_t;

   localparam logic [7:0] AFF_C       = 8'h63;
   localparam logic [7:0] INV_AFF_C   = 8'h05;
   localparam logic [1:0] GF4_PHI     = 2'b10;
   localparam logic [3:0] GF16_LAMBDA = 4'b1000;

   function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
      return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
   endfunction

   // phi * a^2 with phi = w collapses to a bit swap
   function automatic logic [1:0] gf4_sq_scale(input logic [1:0] a);
      return {a[0], a[1]};
   endfunction

   function automatic logic [1:0] gf4_inv(input logic [1:0] a);
      return {a[1], a[1] ^ a[0]};
   endfunction

   function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
      logic [1:0] ac;
      ac = gf4_mul(x[3:2], y[3:2]);
      return {ac ^ gf4_mul(x[3:2], y[1:0]) ^ gf4_mul(x[1:0], y[3:2]),
              gf4_mul(ac, GF4_PHI) ^ gf4_mul(x[1:0], y[1:0])};
   endfunction

   function automatic logic [3:0] gf16_sq_scale(input logic [3:0] x);
      return gf16_mul(gf16_mul(x, x), GF16_LAMBDA);
   endfunction

   function automatic logic [3:0] gf16_inv(input logic [3:0] x);
      logic [1:0] delta, di;
      delta = gf4_sq_scale(x[3:2]) ^ gf4_mul(x[3:2], x[1:0]) ^ gf4_mul(x[1:0], x[1:0]);
      di    = gf4_inv(delta);
      return {gf4_mul(x[3:2], di), gf4_mul(x[3:2] ^ x[1:0], di)};
   endfunction

   function automatic logic [7:0] gf256_inv(input logic [7:0] g);
      logic [3:0] delta, di;
      delta = gf16_sq_scale(g[7:4]) ^ gf16_mul(g[7:4], g[3:0]) ^ gf16_mul(g[3:0], g[3:0]);
      di    = gf16_inv(delta);
      return {gf16_mul(g[7:4], di), gf16_mul(g[7:4] ^ g[3:0], di)};
   endfunction

   function automatic logic [7:0] map8(input bmat_t m, input logic [7:0] v);
      logic [7:0] r;
      r = '0;
      for (int j = 0; j < 8; j++)
         if (v[j]) r = r ^ m[j];
      return r;
   endfunction

   function automatic logic [7:0] aes_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return r;
   endfunction

   // Columns are the AES-field images of w, Y, Z and their products, found as polynomial roots
   function automatic bmat_t calc_g2b();
      logic [7:0] c, w, y, z;
      logic       fw, fy, fz;
      bmat_t      m;
      w = '0; y = '0; z = '0; fw = 1'b0; fy = 1'b0; fz = 1'b0;
      for (int i = 2; i < 256; i++) begin
         c = 8'(i);
         if (!fw && ((aes_mul(c, c) ^ c) == 8'h01)) begin w = c; fw = 1'b1; end
      end
      for (int i = 0; i < 256; i++) begin
         c = 8'(i);
         if (!fy && ((aes_mul(c, c) ^ c) == w)) begin y = c; fy = 1'b1; end
      end
      for (int i = 0; i < 256; i++) begin
         c = 8'(i);
         if (!fz && ((aes_mul(c, c) ^ c) == aes_mul(y, w))) begin z = c; fz = 1'b1; end
      end
      m[0] = 8'h01;          m[1] = w;
      m[2] = y;              m[3] = aes_mul(y, w);
      m[4] = z;              m[5] = aes_mul(z, w);
      m[6] = aes_mul(z, y);  m[7] = aes_mul(m[6], w);
      return m;
   endfunction

   function automatic bmat_t calc_b2g(input bmat_t g2b_m);
      logic [7:0] y;
      bmat_t      m;
      m = '0;
      for (int i = 0; i < 256; i++) begin
         y = map8(g2b_m, 8'(i));
         for (int j = 0; j < 8; j++)
            if (y == (8'h01 << j)) m[j] = 8'(i);
      end
      return m;
   endfunction

   localparam bmat_t G2B = calc_g2b();
   localparam bmat_t B2G = calc_b2g(G2B);

   function automatic logic [7:0] b2g(input logic [7:0] v);
      return map8(B2G, v);
   endfunction

   function automatic logic [7:0] g2b(input logic [7:0] v);
      return map8(G2B, v);
   endfunction

endpackage

// File: rtl/inv_sbox_lane.sv
// One AES inverse S-box lane: inverse affine, composite-field inversion, map back.
// Combinational by default; INV_SUB_BYTES_PIPE_EN adds a register before the g2b map (1 cycle).
module inv_sbox_lane
   import aes_gf_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   logic [7:0] aff;
   logic [7:0] inv_g;

   always_comb begin
      aff   = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
            ^ {in_byte[1:0], in_byte[7:2]} ^ INV_AFF_C;
      inv_g = gf256_inv(b2g(aff));
   end

`ifdef INV_SUB_BYTES_PIPE_EN
   logic [7:0] inv_q, inv_d;

   always_comb inv_d = inv_g;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inv_q <= '0;
      else        inv_q <= inv_d;
   end

   assign out_byte = g2b(inv_q);
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
   assign out_byte       = g2b(inv_g);
`endif

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes, LANES bytes/cycle; out_valid 16/LANES cycles after accept (+1 with INV_SUB_BYTES_PIPE_EN).
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the output handshake completes.
module inv_sub_bytes_seq
   import aes_gf_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   localparam int NCHUNK = 16 / LANES;
   localparam int CNT_W  = $clog2(NCHUNK) + 1;
`ifdef INV_SUB_BYTES_PIPE_EN
   localparam int LAST_CNT = NCHUNK;
`else
   localparam int LAST_CNT = NCHUNK - 1;
`endif

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [15:0][7:0]       buf_q, buf_d;
   logic                   init_q, init_d;
   logic [CNT_W-1:0]       rd_chunk, wr_chunk;
   logic                   wr_en;
   logic [LANES-1:0][7:0]  lane_in, lane_out;

   // Byte 0 lives in buf_q[15] so the packed buffer matches the port bit order
   assign in_ready  = init_q && (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign state_out = buf_q;

   always_comb begin
`ifdef INV_SUB_BYTES_PIPE_EN
      rd_chunk = (cnt_q == CNT_W'(LAST_CNT)) ? '0 : cnt_q;
      wr_chunk = cnt_q - 1'b1;
      wr_en    = (state_q == ST_BUSY) && (cnt_q != '0);
`else
      rd_chunk = cnt_q;
      wr_chunk = cnt_q;
      wr_en    = (state_q == ST_BUSY);
`endif
      for (int k = 0; k < LANES; k++)
         lane_in[k] = buf_q[4'(15 - (int'(rd_chunk) * LANES + k))];
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      inv_sbox_lane u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_byte  (lane_in[k]),
         .out_byte (lane_out[k])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      init_d  = 1'b1;
      if (wr_en)
         for (int k = 0; k < LANES; k++)
            buf_d[4'(15 - (int'(wr_chunk) * LANES + k))] = lane_out[k];
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               buf_d   = state_in;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q == CNT_W'(LAST_CNT)) state_d = ST_DONE;
            else                           cnt_d   = cnt_q + 1'b1;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         init_q  <= init_d;
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq; expected states come from an independently built GF(2^8) S-box model.
module tb_inv_sub_bytes_seq;

   localparam int LANES  = 4;
   localparam int NCHUNK = 16 / LANES;
`ifdef INV_SUB_BYTES_PIPE_EN
   localparam int LAT = NCHUNK + 1;
`else
   localparam int LAT = NCHUNK;
`endif

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] state_in, state_out;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   sbox [256];
   logic [7:0]   isbox[256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inv_sub_bytes_seq #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out)
   );

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic build_model();
      logic [7:0] p, x;
      for (int v = 0; v < 256; v++) begin
         x = 8'(v);
         p = 8'h01;
         for (int e = 0; e < 254; e++) p = mul(p, x);
         sbox[v] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
         isbox[sbox[v]] = x;
      end
   endtask

   function automatic logic [127:0] model_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isbox[s[127-8*i -: 8]];
      return r;
   endfunction

   task automatic send(input logic [127:0] s, output bit ok);
      int n;
      in_valid = 1'b1;
      state_in = s;
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      ok = in_ready;
      if (ok) begin
         @(posedge clk); #1;
         exp_q.push_back(model_state(s));
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok, output int lat);
      out_ready = 1'b1;
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      ok = out_valid;
   endtask

   task automatic ack();
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (state_out !== 128'h0) begin errors++; $display("FAIL rst_state_out: got %h want 0", state_out); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early: got %b want 0", in_ready); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_zero();
      bit ok; int lat; logic [127:0] e;
      send(128'h0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_accept: got timeout want accept"); return; end
      wait_out(ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL zero_out: got timeout want out_valid"); return; end
      e = exp_q.pop_front();
      checks++; if (lat != LAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
      checks++; if (state_out !== {16{8'h52}}) begin errors++; $display("FAIL zero_data: got %h want %h", state_out, {16{8'h52}}); end
      checks++; if (state_out !== e) begin errors++; $display("FAIL zero_model: got %h want %h", state_out, e); end
      ack();
   endtask

   task automatic test_known();
      bit ok; int lat; logic [127:0] e, lit;
      lit = {8'h00, 8'h01, 8'h53, 8'hFF, {12{8'h52}}};
      send({8'h63, 8'h7C, 8'hED, 8'h16, 96'h0}, ok);
      checks++; if (!ok) begin errors++; $display("FAIL known_accept: got timeout want accept"); return; end
      wait_out(ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL known_out: got timeout want out_valid"); return; end
      e = exp_q.pop_front();
      checks++; if (state_out !== lit) begin errors++; $display("FAIL known_data: got %h want %h", state_out, lit); end
      checks++; if (state_out !== e) begin errors++; $display("FAIL known_model: got %h want %h", state_out, e); end
      ack();
   endtask

   task automatic test_exhaustive();
      bit ok; int lat; logic [127:0] s, id, e; logic [7:0] v;
      for (int j = 0; j < 256; j++) begin
         for (int i = 0; i < 16; i++) begin
            v = 8'(j + i);
            s[127-8*i -: 8]  = sbox[v];
            id[127-8*i -: 8] = v;
         end
         send(s, ok);
         checks++; if (!ok) begin errors++; $display("FAIL exh_accept %0d: got timeout want accept", j); return; end
         wait_out(ok, lat);
         checks++; if (!ok) begin errors++; $display("FAIL exh_out %0d: got timeout want out_valid", j); return; end
         e = exp_q.pop_front();
         checks++; if (state_out !== e) begin errors++; $display("FAIL exh_model %0d: got %h want %h", j, state_out, e); end
         checks++; if (state_out !== id) begin errors++; $display("FAIL exh_roundtrip %0d: got %h want %h", j, state_out, id); end
         ack();
      end
   endtask

   task automatic test_backpressure();
      bit ok; int lat, n; logic [127:0] s1, s2, held, e;
      s1 = {$urandom, $urandom, $urandom, $urandom};
      s2 = {$urandom, $urandom, $urandom, $urandom};
      send(s1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got timeout want accept"); return; end
      in_valid  = 1'b1;
      state_in  = s2;
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      checks++; if (!out_valid) begin errors++; in_valid = 1'b0; $display("FAIL bp_out: got timeout want out_valid"); return; end
      held = state_out;
      e = exp_q.pop_front();
      checks++; if (held !== e) begin errors++; $display("FAIL bp_data: got %h want %h", held, e); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || state_out !== held || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold %0d: got v=%b r=%b d=%h want v=1 r=0 d=%h", c, out_valid, in_ready, state_out, held);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
      @(posedge clk); #1;
      exp_q.push_back(model_state(s2));
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got in_ready %b want 0", in_ready); end
      wait_out(ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL bp_second_out: got timeout want out_valid"); return; end
      e = exp_q.pop_front();
      checks++; if (state_out !== e) begin errors++; $display("FAIL bp_second_data: got %h want %h", state_out, e); end
      ack();
   endtask

   task automatic test_reset_mid();
      bit ok; int lat; logic [127:0] e, s;
      send({4{32'hDEADBEEF}}, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_accept: got timeout want accept"); return; end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready: got %b want 0", in_ready); end
      checks++; if (state_out !== 128'h0) begin errors++; $display("FAIL rm_state_out: got %h want 0", state_out); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready_release: got %b want 1", in_ready); end
      s = 128'h00112233445566778899AABBCCDDEEFF;
      send(s, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_next_accept: got timeout want accept"); return; end
      wait_out(ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL rm_next_out: got timeout want out_valid"); return; end
      e = exp_q.pop_front();
      checks++; if (state_out !== e) begin errors++; $display("FAIL rm_next_data: got %h want %h", state_out, e); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rm_next_latency: got %0d want %0d", lat, LAT); end
      ack();
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      logic [127:0] st[N];
      for (int i = 0; i < N; i++) st[i] = {$urandom, $urandom, $urandom, $urandom};
      fork
         begin : producer
            int n;
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
               state_in = st[i];
               n = 0;
               while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
               if (!in_ready) begin
                  checks++; errors++;
                  $display("FAIL b2b_accept %0d: got timeout want accept", i);
                  break;
               end
               @(posedge clk); #1;
               exp_q.push_back(model_state(st[i]));
            end
            in_valid = 1'b0;
         end
         begin : consumer
            int n, prev;
            logic [127:0] e;
            out_ready = 1'b1;
            prev = 0;
            for (int i = 0; i < N; i++) begin
               n = 0;
               while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
               checks++;
               if (!out_valid) begin errors++; $display("FAIL b2b_out %0d: got timeout want out_valid", i); break; end
               checks++;
               if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_queue %0d: got empty want entry", i); break; end
               e = exp_q.pop_front();
               checks++; if (state_out !== e) begin errors++; $display("FAIL b2b_data %0d: got %h want %h", i, state_out, e); end
               if (i > 0) begin
                  checks++;
                  if (cyc - prev != LAT + 2) begin errors++; $display("FAIL b2b_period %0d: got %0d want %0d", i, cyc - prev, LAT + 2); end
               end
               prev = cyc;
               @(posedge clk); #1;
            end
            out_ready = 1'b0;
         end
      join
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_out: got %b want 0", out_valid); end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      state_in  = '0;
      build_model();
      test_reset();
      test_zero();
      test_known();
      test_exhaustive();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Sequential AES InvSubBytes engine: takes a 128-bit AES state and applies the inverse S-box to all 16 bytes, LANES bytes per cycle.
- Each inverse S-box is computed in composite field GF(((2^2)^2)^2): inverse affine, then basis map to the composite field, then GF(2^8) inversion, then map back.
- Sits in the decryption datapath between InvShiftRows and AddRoundKey; it is the decryption counterpart of the forward SubBytes block.

Parameters:
- LANES, 4, inverse S-box lanes per cycle; legal values 1, 2, 4, 8, 16.
- CNT_W, $clog2(16/LANES)+1, width of the chunk counter (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state
- state_in  input  128  state; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  state_out is valid
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  InvSubBytes(state_in), same byte order

Behaviour:
- Interface decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: in_ready=0 during reset and 1 the cycle after release; out_valid=0; state_out=0; FSM=IDLE; counter=0.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch state_in into a 128-bit work buffer, set cnt=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced in place by their inverse S-box values, and cnt increments.
  - BUSY exit: after chunk 16/LANES-1 is written, go to DONE.
  - DONE: out_valid=1 and state_out=buffer. Both are held stable while out_ready=0. On out_ready, go to IDLE and drop out_valid in the next cycle.
- Latency: out_valid rises 16/LANES cycles after the accepting edge (LANES=4: 4 cycles; LANES=16: 1 cycle).
- Throughput: one state per 16/LANES+2 cycles minimum.
- in_ready is low in BUSY and DONE. A new input is never accepted in the same cycle as an output handshake.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Per-byte function: x = A_inv·(b xor 0x63), i.e. x = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 0x05.
- The result is then x^-1 in GF(2^8) modulo 0x11B, with 0^-1 = 0. The inversion runs in the composite field through the b2g/g2b basis maps.
- Reset asserted mid-operation: immediate return to IDLE, partial result discarded, out_valid=0.
- Counter never wraps. A value of 16/LANES is unreachable because BUSY exits on the last chunk.
- state_out is driven only from the buffer. It is not defined as X outside DONE; it holds the last buffer value.

Optional Feature:
- Macro: INV_SUB_BYTES_PIPE_EN.
- Defined:
  - Each lane has a register between GF(2^8) inversion and the g2b output map, and the write-back is delayed one cycle.
  - BUSY lasts one extra cycle to drain the pipe.
  - Latency becomes 16/LANES+1 cycles.
  - Results are bit-identical to the non-pipelined build.
- Undefined: the lane is fully combinational within one cycle; latency is as stated above.

Decomposition:
- Package aes_gf_pkg holds:
  - the 8x8 basis matrices B2G and G2B;
  - the affine constants 8'h63 and 8'h05;
  - the FSM state enum for IDLE, BUSY and DONE;
  - the GF(2^2) and GF(2^4) multiply, square-scale and inverse functions shared with the forward SubBytes block.
- One sub-module, inv_sbox_lane: an 8-bit in, 8-bit out combinational inverse S-box. It carries an optional mid-register under INV_SUB_BYTES_PIPE_EN with clk and rst_n ports.
- Top instantiates LANES copies and drives them with a byte mux indexed by cnt.

Test Plan:
1. All-zero input: state_in = 128'h0 -> state_out = 128'h5252...52 (all 16 bytes 0x52), out_valid exactly 16/LANES cycles after accept.
2. Known bytes: state_in bytes 0..3 = 63,7C,ED,16, rest 00 -> state_out bytes 0..3 = 00,01,53,FF, rest 52.
3. Exhaustive: sweep all 256 byte values through every lane position -> matches the FIPS-197 InvSbox table; InvSbox(SubBytes model(v)) = v for all v.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable; in_ready=0; second in_valid not accepted until after the out handshake.
5. Reset mid-operation: assert rst_n=0 in the second BUSY cycle -> out_valid=0 and in_ready=0 immediately; in_ready=1 one cycle after release; the next state processes correctly.
6. Back-to-back with in_valid held high and out_ready=1 -> one result per 16/LANES+2 cycles, no drops or duplicates. Repeat with INV_SUB_BYTES_PIPE_EN defined: latency is one cycle longer and results are identical.
